la_iopwrseq: RTL and testbench

LA_IOPWRSEQ -- requirements
Module: la_iopwrseq

---
 rtl/la_iopwrseq_pkg.sv | 21 ++
 rtl/la_iopwrseq_cnt.sv | 24 ++
 rtl/la_iopwrseq.sv | 181 ++++++++++++++++++
 tb/tb_la_iopwrseq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/la_iopwrseq_pkg.sv
// rtl/la_iopwrseq_pkg.sv - shared state encoding and width helpers for the pad-ring power sequencer
package la_iopwrseq_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    UP_SETTLE   = 3'd1,
    UP_WAIT     = 3'd2,
    ON          = 3'd3,
    DOWN_SETTLE = 3'd4,
    FAULT       = 3'd5
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int dly, input int tmo);
    return $clog2(((dly > tmo) ? dly : tmo) + 1);
  endfunction

endpackage

// File: rtl/la_iopwrseq_cnt.sv
// rtl/la_iopwrseq_cnt.sv - saturating cycle counter for settle/timeout timing
module la_iopwrseq_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (inc && !sat)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/la_iopwrseq.sv
// rtl/la_iopwrseq.sv - thermometer-coded supply/clamp power sequencer
// Optional ON-state pgood watchdog: define LA_IOPWRSEQ_WDOG_EN.
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter string PROP = "DEFAULT",
  parameter string SIDE = "NO",
  parameter int    N    = 4,
  parameter int    DLY  = 4,
  parameter int    TMO  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [N-1:0]              pgood,
  output logic [N-1:0]              chen,
  output logic                      ready,
  output logic                      fault,
  output logic [idx_width(N)-1:0]   fchan
);

  localparam int FW = idx_width(N);
  localparam int CW = cnt_width(DLY, TMO);
  localparam logic [CW-1:0] DLY_LAST = CW'(DLY - 1);
  localparam logic [CW-1:0] DLY_END  = CW'(DLY);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
  localparam logic [FW-1:0] IDX_LAST = FW'(N - 1);

  // Cell selectors only matter to the external pad-ring mapping; nothing is instantiated here.
  if (SIDE != "NO" && SIDE != "SO" && SIDE != "EA" && SIDE != "WE") begin : g_side_unknown
  end
  if (PROP == "") begin : g_prop_empty
  end

  state_t         state, state_n;
  logic [FW-1:0]  idx, idx_n;
  logic [N-1:0]   chen_n;
  logic           fault_n;
  logic [FW-1:0]  fchan_n;
  logic [CW-1:0]  cnt;
  logic           cnt_clr, cnt_inc, cnt_sat;
`ifdef LA_IOPWRSEQ_WDOG_EN
  logic [N-1:0]   lowprev, lowprev_n, bad;
`endif

  la_iopwrseq_cnt #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .sat   (cnt_sat)
  );

  assign ready = (state == ON);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      chen  <= '0;
      fault <= 1'b0;
      fchan <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      chen  <= chen_n;
      fault <= fault_n;
      fchan <= fchan_n;
    end
  end

`ifdef LA_IOPWRSEQ_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lowprev <= '0;
    else       lowprev <= lowprev_n;
  end
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    chen_n  = chen;
    fault_n = fault;
    fchan_n = fchan;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef LA_IOPWRSEQ_WDOG_EN
    lowprev_n = '0;
    bad       = ~pgood & lowprev;
`endif
    case (state)
      IDLE: begin
        if (en) begin
          state_n   = UP_SETTLE;
          idx_n     = '0;
          chen_n    = '0;
          chen_n[0] = 1'b1;
          fault_n   = 1'b0;
          fchan_n   = '0;
          cnt_clr   = 1'b1;
        end
      end
      UP_SETTLE: begin
        if (!en) begin
          state_n     = DOWN_SETTLE;
          chen_n[idx] = 1'b0;
          cnt_clr     = 1'b1;
        end else if (cnt == DLY_LAST || cnt_sat) begin
          state_n = UP_WAIT;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      UP_WAIT: begin
        if (!en) begin
          state_n     = DOWN_SETTLE;
          chen_n[idx] = 1'b0;
          cnt_clr     = 1'b1;
        end else if (pgood[idx]) begin
          cnt_clr = 1'b1;
          if (idx == IDX_LAST) begin
            state_n = ON;
          end else begin
            state_n       = UP_SETTLE;
            idx_n         = idx + 1'b1;
            chen_n[idx_n] = 1'b1;
          end
        end else if (cnt == TMO_LAST || cnt_sat) begin
          state_n = FAULT;
          chen_n  = '0;
          fault_n = 1'b1;
          fchan_n = idx;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ON: begin
        if (!en) begin
          state_n     = DOWN_SETTLE;
          chen_n[idx] = 1'b0;
          cnt_clr     = 1'b1;
        end
`ifdef LA_IOPWRSEQ_WDOG_EN
        else if (|bad) begin
          state_n = FAULT;
          chen_n  = '0;
          fault_n = 1'b1;
          for (int k = N - 1; k >= 0; k--)
            if (bad[k]) fchan_n = FW'(k);
        end else begin
          lowprev_n = ~pgood;
        end
`endif
      end
      DOWN_SETTLE: begin
        // en is deliberately not looked at: shutdown always completes to IDLE.
        if (cnt == DLY_END || cnt_sat) begin
          cnt_clr = 1'b1;
          if (idx == '0) begin
            state_n = IDLE;
          end else begin
            idx_n         = idx - 1'b1;
            chen_n[idx_n] = 1'b0;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FAULT: begin
        if (!en) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        chen_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_la_iopwrseq.sv
// tb/tb_la_iopwrseq.sv - self-checking bench for la_iopwrseq against a closed-form timeline model
module tb_la_iopwrseq;

  localparam int N   = 4;
  localparam int DLY = 4;
  localparam int TMO = 8;
  localparam int P   = DLY + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [N-1:0] pgood;
  logic [N-1:0] chen;
  logic         ready;
  logic         fault;
  logic [1:0]   fchan;

  int npass = 0;
  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  la_iopwrseq #(.N(N), .DLY(DLY), .TMO(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .pgood (pgood),
    .chen  (chen),
    .ready (ready),
    .fault (fault),
    .fchan (fchan)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Edge (counted from the first edge that sees en=1) at which channel f times out.
  function automatic int fe(input int f);
    return 1 + f * P + DLY + TMO;
  endfunction

  // Number of enabled channels after edge t of a power-up whose first bad channel is f (N = none).
  function automatic int cu(input int t, input int f);
    int c, lim;
    if (t <= 0) return 0;
    if (f < N && t >= fe(f)) return 0;
    lim = (f < N) ? f + 1 : N;
    c = (t - 1) / P + 1;
    return (c < lim) ? c : lim;
  endfunction

  function automatic logic [N-1:0] th(input int c);
    logic [N-1:0] v = '0;
    for (int i = 0; i < c; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Power-up with bad channel f; en drops before edge d (0 = never); reen re-raises en during shutdown.
  task automatic scenario(input int f, input int d, input bit reen);
    int m, last, c, rdy, flt, idle_t;
    pgood = '1;
    if (f < N) begin
      pgood = 4'($urandom);
      for (int i = 0; i < f; i++) pgood[i] = 1'b1;
      pgood[f] = 1'b0;
    end
    m      = (d > 0) ? cu(d - 1, f) : 0;
    idle_t = d + m * P;
    last   = (d > 0) ? idle_t + 1 : fe(f) + 3;
    for (int t = 1; t <= last; t++) begin
      if (d == 0 || t < d) en = 1'b1;
      else if (reen)       en = ((t >= d + 2 && t <= d + 4) || t >= idle_t - 2);
      else                 en = 1'b0;
      step();
      if (d == 0 || t < d) begin
        c   = cu(t, f);
        rdy = (f == N && t >= 1 + N * P) ? 1 : 0;
        flt = (f < N && t >= fe(f)) ? 1 : 0;
      end else if (t <= idle_t) begin
        c = m - 1 - (t - d) / P;
        if (c < 0) c = 0;
        rdy = 0;
        flt = 0;
      end else begin
        c   = reen ? 1 : 0;
        rdy = 0;
        flt = 0;
      end
      chk("chen", chen, th(c));
      chk("ready", ready, rdy);
      chk("fault", fault, flt);
    end
    if (d == 0) begin
      chk("fchan", fchan, f);
      en = 1'b0;
      step();
      chk("fault_hold", fault, 1);
      chk("fchan_hold", fchan, f);
      chk("chen_idle", chen, 0);
    end
    if (reen) begin
      en = 1'b0;
      for (int i = 0; i < P + 2; i++) step();
      chk("chen_drain", chen, 0);
    end
  endtask

  initial begin
    int f, d;
    reset = 1'b1;
    en    = 1'b0;
    pgood = '1;
    #1;
    chk("rst_chen", chen, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fchan", fchan, 0);
    step();
    reset = 1'b0;
    step();
    chk("idle_chen", chen, 0);

    // Full power-up then shutdown from ON.
    scenario(N, 1 + N * P + 2, 1'b0);
    // Channel 2 never reports power-good.
    scenario(2, 0, 1'b0);
    // en bounces during shutdown; power-up restarts only after IDLE.
    scenario(N, 1 + N * P + 1, 1'b1);

    // Reset in the middle of UP_SETTLE(1).
    en = 1'b1;
    pgood = '1;
    for (int i = 0; i < 7; i++) step();
    chk("mid_chen", chen, 4'b0011);
    #2 reset = 1'b1;
    #1;
    chk("async_chen", chen, 0);
    chk("async_ready", ready, 0);
    chk("async_fault", fault, 0);
    chk("async_fchan", fchan, 0);
    step();
    chk("held_chen", chen, 0);
    reset = 1'b0;
    step();
    chk("release_chen", chen, 4'b0001);
    en = 1'b0;
    for (int i = 0; i < P + 2; i++) step();
    chk("release_drain", chen, 0);

    // pgood glitches while ON.
    en = 1'b1;
    pgood = '1;
    for (int i = 0; i < 1 + N * P; i++) step();
    chk("wd_ready", ready, 1);
    pgood[1] = 1'b0;
    step();
    pgood = '1;
    step();
    chk("wd_glitch_fault", fault, 0);
    chk("wd_glitch_ready", ready, 1);
    pgood[1] = 1'b0;
    step();
    step();
`ifdef LA_IOPWRSEQ_WDOG_EN
    chk("wd_fault", fault, 1);
    chk("wd_fchan", fchan, 1);
    chk("wd_chen", chen, 0);
    pgood = '1;
    en = 1'b0;
    step();
    chk("wd_exit_chen", chen, 0);
`else
    chk("nowd_ready", ready, 1);
    chk("nowd_chen", chen, 4'b1111);
    chk("nowd_fault", fault, 0);
    pgood = '1;
    en = 1'b0;
    for (int i = 0; i < N * P + 1; i++) step();
    chk("nowd_exit_chen", chen, 0);
    chk("nowd_exit_ready", ready, 0);
`endif

    for (int s = 0; s < 8; s++) begin
      f = $urandom_range(0, N);
      if (f == N)                  d = $urandom_range(2, 1 + N * P + 4);
      else if ($urandom_range(0, 1)) d = 0;
      else                         d = $urandom_range(2, fe(f) - 1);
      scenario(f, d, 1'b0);
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
